pci_bus_arbiter: RTL and testbench

Central arbiter for the shared PCI-style bus that the `Device` instances drive. It collects the active-low `REQ_N` lines from up to `N_MASTERS` devices and grants the bus with a round-robin policy. It watches `FRAME_N`/`IRDY_N` to track transaction start and completion, and inserts a turnaround gap between owners. It also revokes a grant that is never used. It sits at the top level beside the devices and drives each device's `GNT` input.

---
 rtl/pci_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_pci_bus_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pci_bus_arbiter.sv
// rtl/pci_bus_arbiter.sv - round-robin grant arbiter for the shared PCI-style bus
//
// Ports:
//   CLK          rising-edge clock
//   RST          synchronous active-high reset
//   REQ_N        per-device bus request, active low
//   FRAME_N      shared bus FRAME, active low (start/continuation of a transaction)
//   IRDY_N       shared bus IRDY, active low
//   GNT_N        per-device grant, active low; one-cold or all ones
//   BUS_OWNER    index of the current or most recent grantee
//   OWNER_VALID  high while a grantee holds the bus (GRANT or BUSY)
//   TIMEOUT_P    one-cycle pulse when a grant is revoked because it was never used

module pci_bus_arbiter #(
    parameter int N_MASTERS     = 4,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] REQ_N,
    input  logic                 FRAME_N,
    input  logic                 IRDY_N,
    output logic [N_MASTERS-1:0] GNT_N,
    output logic [2:0]           BUS_OWNER,
    output logic                 OWNER_VALID,
    output logic                 TIMEOUT_P
);

    localparam int CW = $clog2(GRANT_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_GAP
    } state_t;

    state_t               state, state_nxt;
    logic [2:0]           last_owner, last_owner_nxt;
    logic [2:0]           bus_owner_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [N_MASTERS-1:0] gnt_n_nxt;
    logic                 owner_valid_nxt;
    logic                 timeout_p_nxt;

    // Round-robin search: requests as an 8-bit active-high vector so any
    // 3-bit index is in range regardless of N_MASTERS.
    logic [7:0]           req_act;
    logic [3:0]           idx;
    logic [2:0]           winner;
    logic                 any_req;

    always_comb begin
        req_act                  = '0;
        req_act[N_MASTERS-1:0]   = ~REQ_N;
        winner                   = '0;
        any_req                  = 1'b0;
        idx                      = '0;
        // Scan offsets from farthest to nearest so the nearest requester
        // after last_owner is the final (winning) assignment.
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            idx = {1'b0, last_owner} + 4'd1 + 4'(i);
            if (idx >= 4'(N_MASTERS)) begin
                idx = idx - 4'(N_MASTERS);
            end
            if (req_act[idx[2:0]]) begin
                winner  = idx[2:0];
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        gnt_n_nxt       = GNT_N;
        bus_owner_nxt   = BUS_OWNER;
        owner_valid_nxt = OWNER_VALID;
        timeout_p_nxt   = 1'b0;
        last_owner_nxt  = last_owner;
        cnt_nxt         = cnt;

        case (state)
            S_IDLE: begin
                gnt_n_nxt       = '1;
                owner_valid_nxt = 1'b0;
                if (any_req) begin
                    gnt_n_nxt       = ~(N_MASTERS'(1) << winner);
                    bus_owner_nxt   = winner;
                    owner_valid_nxt = 1'b1;
                    cnt_nxt         = '0;
                    state_nxt       = S_GRANT;
                end
            end
            S_GRANT: begin
                // FRAME_N low beats withdrawal and timeout in the same cycle.
                if (!FRAME_N) begin
                    last_owner_nxt = BUS_OWNER;
                    state_nxt      = S_BUSY;
                end else if (!req_act[BUS_OWNER]) begin
                    // Withdrawn request keeps last_owner, so priority is unchanged.
                    gnt_n_nxt       = '1;
                    owner_valid_nxt = 1'b0;
                    state_nxt       = S_GAP;
                end else if (cnt == CW'(GRANT_TIMEOUT - 1)) begin
                    // Stalled owner is charged with a turn and loses priority.
                    gnt_n_nxt       = '1;
                    owner_valid_nxt = 1'b0;
                    timeout_p_nxt   = 1'b1;
                    last_owner_nxt  = BUS_OWNER;
                    state_nxt       = S_GAP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_BUSY: begin
                if (FRAME_N && IRDY_N) begin
                    gnt_n_nxt       = '1;
                    owner_valid_nxt = 1'b0;
                    state_nxt       = S_GAP;
                end
            end
            S_GAP: begin
                gnt_n_nxt       = '1;
                owner_valid_nxt = 1'b0;
                state_nxt       = S_IDLE;
            end
            default: begin
                gnt_n_nxt       = '1;
                owner_valid_nxt = 1'b0;
                state_nxt       = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            GNT_N       <= '1;
            BUS_OWNER   <= '0;
            OWNER_VALID <= 1'b0;
            TIMEOUT_P   <= 1'b0;
            last_owner  <= 3'(N_MASTERS - 1);
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            GNT_N       <= gnt_n_nxt;
            BUS_OWNER   <= bus_owner_nxt;
            OWNER_VALID <= owner_valid_nxt;
            TIMEOUT_P   <= timeout_p_nxt;
            last_owner  <= last_owner_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb/tb_pci_bus_arbiter.sv - self-checking bench for pci_bus_arbiter

module tb_pci_bus_arbiter;

    localparam int N  = 4;
    localparam int GT = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic [N-1:0] REQ_N;
    logic         FRAME_N;
    logic         IRDY_N;
    logic [N-1:0] GNT_N;
    logic [2:0]   BUS_OWNER;
    logic         OWNER_VALID;
    logic         TIMEOUT_P;

    int checks = 0;
    int errors = 0;

    pci_bus_arbiter #(.N_MASTERS(N), .GRANT_TIMEOUT(GT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ_N       (REQ_N),
        .FRAME_N     (FRAME_N),
        .IRDY_N      (IRDY_N),
        .GNT_N       (GNT_N),
        .BUS_OWNER   (BUS_OWNER),
        .OWNER_VALID (OWNER_VALID),
        .TIMEOUT_P   (TIMEOUT_P)
    );

    always #5 CLK = ~CLK;

    // Reference model: who holds the bus (-1 = nobody), whether the
    // transaction has started, edges elapsed since the grant, turnaround flag.
    int m_holder;
    int m_owner;
    int m_last;
    int m_since;
    bit m_started;
    bit m_turn;
    bit m_to;

    function automatic int rr_pick(input logic [N-1:0] req_n, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (req_n[c] == 1'b0) return c;
        end
        return -1;
    endfunction

    task automatic release_bus();
        m_holder  = -1;
        m_started = 0;
        m_turn    = 1;
    endtask

    task automatic model_edge();
        int w;
        if (RST) begin
            m_holder = -1; m_owner = 0; m_last = N - 1; m_since = 0;
            m_started = 0; m_turn = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_turn) begin
                m_turn = 0;
            end else if (m_holder < 0) begin
                w = rr_pick(REQ_N, m_last);
                if (w >= 0) begin
                    m_holder = w; m_owner = w; m_since = 0; m_started = 0;
                end
            end else if (!m_started) begin
                m_since++;
                if (!FRAME_N) begin
                    m_started = 1;
                    m_last    = m_holder;
                end else if (REQ_N[m_holder]) begin
                    release_bus();
                end else if (m_since == GT) begin
                    m_last = m_holder;
                    m_to   = 1;
                    release_bus();
                end
            end else if (FRAME_N && IRDY_N) begin
                release_bus();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the inputs about to be sampled, then
    // compare every output 1 time unit after the edge.
    task automatic step();
        logic [N-1:0] e_gnt;
        model_edge();
        @(posedge CLK);
        #1;
        e_gnt = '1;
        if (m_holder >= 0) e_gnt[m_holder] = 1'b0;
        chk("gnt_n", 32'(GNT_N), 32'(e_gnt));
        chk("bus_owner", 32'(BUS_OWNER), 32'(m_owner));
        chk("owner_valid", 32'(OWNER_VALID), 32'(m_holder >= 0));
        chk("timeout_p", 32'(TIMEOUT_P), 32'(m_to));
        chk("gnt_onecold", 32'($countones(~GNT_N) <= 1), 32'(1));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; REQ_N = '1; FRAME_N = 1'b1; IRDY_N = 1'b1;
        m_holder = -1; m_owner = 0; m_last = N - 1; m_since = 0;
        m_started = 0; m_turn = 0; m_to = 0;

        // Reset state
        do_reset();
        chk("rst_gnt", 32'(GNT_N), 32'hF);
        chk("rst_owner", 32'(BUS_OWNER), 32'd0);
        chk("rst_valid", 32'(OWNER_VALID), 32'd0);

        // Single requester, 3-cycle transaction, then GAP
        REQ_N = 4'b1110; step();
        chk("single_gnt", 32'(GNT_N), 32'hE);
        FRAME_N = 1'b0; step(); step(); step();
        REQ_N = 4'b1111; FRAME_N = 1'b1; IRDY_N = 1'b1; step();
        chk("single_gap_gnt", 32'(GNT_N), 32'hF);
        chk("single_gap_valid", 32'(OWNER_VALID), 32'd0);
        step();

        // Round robin with all requesting
        do_reset();
        REQ_N = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            FRAME_N = 1'b1; step();
            chk("rr_owner", 32'(BUS_OWNER), 32'(k % N));
            FRAME_N = 1'b0; step(); step();
            FRAME_N = 1'b1; IRDY_N = 1'b1; step();
            chk("rr_gap", 32'(GNT_N), 32'hF);
            step();
        end

        // Timeout: device 2 never starts
        REQ_N = 4'b1011; FRAME_N = 1'b1; step();
        chk("to_grant", 32'(GNT_N), 32'hB);
        for (int k = 1; k < GT; k++) step();
        chk("to_held", 32'(GNT_N), 32'hB);
        step();
        chk("to_revoked", 32'(GNT_N), 32'hF);
        chk("to_pulse", 32'(TIMEOUT_P), 32'd1);
        REQ_N = 4'b0011; step();
        chk("to_pulse_end", 32'(TIMEOUT_P), 32'd0);
        step();
        chk("to_next_owner", 32'(BUS_OWNER), 32'd3);
        REQ_N = 4'b1111; step(); step();

        // Withdrawal keeps priority
        do_reset();
        REQ_N = 4'b1101; step();
        chk("wd_grant", 32'(GNT_N), 32'hD);
        REQ_N = 4'b1111; step();
        chk("wd_release", 32'(GNT_N), 32'hF);
        step();
        REQ_N = 4'b1001; step();
        chk("wd_regrant", 32'(BUS_OWNER), 32'd1);
        REQ_N = 4'b1111; step(); step();

        // Reset mid-BUSY
        REQ_N = 4'b1110; step();
        FRAME_N = 1'b0; step(); step();
        RST = 1'b1; step();
        chk("rb_gnt", 32'(GNT_N), 32'hF);
        chk("rb_owner", 32'(BUS_OWNER), 32'd0);
        chk("rb_valid", 32'(OWNER_VALID), 32'd0);
        RST = 1'b0; FRAME_N = 1'b1; REQ_N = 4'b1100; step();
        chk("rb_next", 32'(BUS_OWNER), 32'd0);

        // End of transaction with devices 0 and 2 requesting, last owner 0
        FRAME_N = 1'b0; step();
        REQ_N = 4'b1010; step();
        FRAME_N = 1'b1; IRDY_N = 1'b1; step();
        chk("se_gap", 32'(GNT_N), 32'hF);
        step(); step();
        chk("se_owner", 32'(BUS_OWNER), 32'd2);
        chk("se_gnt", 32'(GNT_N), 32'hB);

        // Randomized traffic: first mostly-idle bus (timeouts), then mixed
        for (int c = 0; c < 2000; c++) begin
            RST = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) begin
                for (int b = 0; b < N; b++) REQ_N[b] = ($urandom_range(0, 9) >= 4);
            end
            if (c < 700) FRAME_N = ($urandom_range(0, 39) != 0);
            else         FRAME_N = ($urandom_range(0, 3) != 0);
            IRDY_N = $urandom_range(0, 1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
